// File: rtl/dbg_bus_bridge_if.sv
// Byte-stream and memory-bus signals of the debug bridge.
// master = bridge side, slave = UART/arbiter/slave-mux side.
interface dbg_bus_bridge_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             bus_req;
    logic             bus_gnt;
    logic [WIDTH-1:0] mbus_aout;
    logic [WIDTH-1:0] mbus_dout;
    logic             mbus_wen;
    logic [WIDTH-1:0] mbus_din;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_gnt, mbus_din,
        output rx_ready, tx_data, tx_valid, bus_req, mbus_aout, mbus_dout, mbus_wen
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_gnt, mbus_din,
        input  rx_ready, tx_data, tx_valid, bus_req, mbus_aout, mbus_dout, mbus_wen
    );
endinterface

// File: rtl/dbg_bus_bridge.sv
// Byte-stream debug bridge: framed W/R/? commands become single-word bus accesses.
// Optional DBG_BUS_BRIDGE_AUTOINC_EN adds address post-increment and the N/M opcodes.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ADDR  | shifting in 4 address bytes, MSB first
// DATA  | shifting in 4 write-data bytes, MSB first
// REQ   | bus_req high, waiting for bus_gnt
// WR    | single write cycle on the bus
// RD1   | read address presented
// RD2   | slave data valid, captured at end of cycle
// RESP  | sending 1 or 4 response bytes
module dbg_bus_bridge #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             reset,
    dbg_bus_bridge_if.master bus,
    output logic             busy
);
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WR, RD1, RD2, RESP} state_t;

    state_t           state;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       byte_cnt;
    logic [2:0]       resp_cnt;
    logic [TW-1:0]    to_cnt;
    logic             is_wr;
    logic             rx_fire;
    logic             tx_fire;

    assign rx_fire = bus.rx_valid & bus.rx_ready;
    assign tx_fire = bus.tx_valid & bus.tx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            byte_cnt      <= '0;
            resp_cnt      <= '0;
            to_cnt        <= '0;
            is_wr         <= 1'b0;
            busy          <= 1'b0;
            bus.rx_ready  <= 1'b1;
            bus.tx_data   <= '0;
            bus.tx_valid  <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.mbus_aout <= '0;
            bus.mbus_dout <= '0;
            bus.mbus_wen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        to_cnt   <= TO_LOAD;
                        case (bus.rx_data)
                            8'h57: begin
                                is_wr <= 1'b1;
                                state <= ADDR;
                            end
                            8'h52: begin
                                is_wr <= 1'b0;
                                state <= ADDR;
                            end
`ifdef DBG_BUS_BRIDGE_AUTOINC_EN
                            8'h4D: begin
                                is_wr <= 1'b1;
                                state <= DATA;
                            end
                            8'h4E: begin
                                is_wr        <= 1'b0;
                                state        <= REQ;
                                bus.rx_ready <= 1'b0;
                                bus.bus_req  <= 1'b1;
                            end
`endif
                            8'h3F: begin
                                state        <= RESP;
                                resp_cnt     <= 3'd1;
                                bus.rx_ready <= 1'b0;
                                bus.tx_valid <= 1'b1;
                                bus.tx_data  <= 8'h42;
                            end
                            default: begin
                                state        <= RESP;
                                resp_cnt     <= 3'd1;
                                bus.rx_ready <= 1'b0;
                                bus.tx_valid <= 1'b1;
                                bus.tx_data  <= 8'h15;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        addr_q   <= {addr_q[WIDTH-9:0], bus.rx_data};
                        to_cnt   <= TO_LOAD;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_wr) begin
                                state <= DATA;
                            end else begin
                                state        <= REQ;
                                bus.rx_ready <= 1'b0;
                                bus.bus_req  <= 1'b1;
                            end
                        end
                    end else if (to_cnt == '0) begin
                        state        <= RESP;
                        resp_cnt     <= 3'd1;
                        bus.rx_ready <= 1'b0;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= 8'h15;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        data_q   <= {data_q[WIDTH-9:0], bus.rx_data};
                        to_cnt   <= TO_LOAD;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state        <= REQ;
                            bus.rx_ready <= 1'b0;
                            bus.bus_req  <= 1'b1;
                        end
                    end else if (to_cnt == '0) begin
                        state        <= RESP;
                        resp_cnt     <= 3'd1;
                        bus.rx_ready <= 1'b0;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= 8'h15;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                REQ: begin
                    if (bus.bus_gnt) begin
                        bus.mbus_aout <= addr_q;
                        if (is_wr) begin
                            bus.mbus_dout <= data_q;
                            bus.mbus_wen  <= 1'b1;
                            state         <= WR;
                        end else begin
                            state <= RD1;
                        end
                    end
                end
                WR: begin
                    state         <= RESP;
                    resp_cnt      <= 3'd1;
                    bus.bus_req   <= 1'b0;
                    bus.mbus_aout <= '0;
                    bus.mbus_dout <= '0;
                    bus.mbus_wen  <= 1'b0;
                    bus.tx_valid  <= 1'b1;
                    bus.tx_data   <= 8'h06;
`ifdef DBG_BUS_BRIDGE_AUTOINC_EN
                    addr_q        <= addr_q + 1'b1;
`endif
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    // data_q doubles as the response shift register
                    data_q        <= bus.mbus_din;
                    state         <= RESP;
                    resp_cnt      <= 3'd4;
                    bus.bus_req   <= 1'b0;
                    bus.mbus_aout <= '0;
                    bus.tx_valid  <= 1'b1;
                    bus.tx_data   <= bus.mbus_din[WIDTH-1 -: 8];
`ifdef DBG_BUS_BRIDGE_AUTOINC_EN
                    addr_q        <= addr_q + 1'b1;
`endif
                end
                RESP: begin
                    if (tx_fire) begin
                        resp_cnt <= resp_cnt - 3'd1;
                        data_q   <= {data_q[WIDTH-9:0], 8'h00};
                        if (resp_cnt == 3'd1) begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            bus.rx_ready <= 1'b1;
                            bus.tx_valid <= 1'b0;
                            bus.tx_data  <= '0;
                        end else begin
                            bus.tx_data <= data_q[WIDTH-9 -: 8];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Directed bench for dbg_bus_bridge: command table plus grant-delay, timeout and reset sequences.
// Build with DBG_BUS_BRIDGE_AUTOINC_EN defined to include the auto-increment vectors.
module tb_dbg_bus_bridge;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    dbg_bus_bridge_if #(.WIDTH(32)) bus_if ();

    dbg_bus_bridge #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // synchronous slave: data appears one cycle after the address
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (bus_if.mbus_wen) mem[bus_if.mbus_aout] = bus_if.mbus_dout;
        bus_if.mbus_din <= mem.exists(bus_if.mbus_aout) ? mem[bus_if.mbus_aout] : 32'h0;
    end

    int          wen_cnt = 0;
    int          req_cnt = 0;
    int          hold_viol = 0;
    logic [31:0] last_aout = '0;
    logic [31:0] last_dout = '0;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_data = '0;
    always @(negedge clk) begin
        if (bus_if.mbus_wen) begin
            wen_cnt++;
            last_aout = bus_if.mbus_aout;
            last_dout = bus_if.mbus_dout;
        end
        if (bus_if.bus_req) req_cnt++;
        if (reset && hold_pend && !(bus_if.tx_valid && bus_if.tx_data == hold_data)) hold_viol++;
        hold_pend = reset && bus_if.tx_valid && !bus_if.tx_ready;
        hold_data = bus_if.tx_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        while (!bus_if.rx_ready && n < 300) begin
            step();
            n++;
        end
        if (!bus_if.rx_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_wait: rx_ready stuck at 0 for byte %h", b);
        end
        step();
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = '0;
    endtask

    task automatic recv_byte(input bit bp, output logic [7:0] b);
        int n = 0;
        b = 'x;
        while (!bus_if.tx_valid && n < 300) begin
            step();
            n++;
        end
        if (!bus_if.tx_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_wait: tx_valid stuck at 0");
            return;
        end
        if (bp) repeat (3) step();
        b = bus_if.tx_data;
        bus_if.tx_ready = 1'b1;
        step();
        bus_if.tx_ready = 1'b0;
    endtask

    typedef struct {
        logic [71:0] cmd;
        int          ncmd;
        logic [31:0] rsp;
        int          nrsp;
        bit          wr;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          use_bus;
    } vec_t;

    vec_t tbl [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         w0;
        int         r0;
        int         n;
        int         errs;

        tbl.push_back('{72'h3F, 1, 32'h42, 1, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{72'h52_00000010, 5, 32'h12345678, 4, 1'b0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{72'h57_00000010_DEADBEEF, 9, 32'h06, 1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{72'h52_00000010, 5, 32'hDEADBEEF, 4, 1'b0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{72'h00, 1, 32'h15, 1, 1'b0, 32'h0, 32'h0, 1'b0});
`ifdef DBG_BUS_BRIDGE_AUTOINC_EN
        tbl.push_back('{72'hA5, 1, 32'h15, 1, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{72'h57_00000020_AAAA0001, 9, 32'h06, 1, 1'b1, 32'h20, 32'hAAAA0001, 1'b1});
        tbl.push_back('{72'h4D_55550002, 5, 32'h06, 1, 1'b1, 32'h21, 32'h55550002, 1'b1});
        tbl.push_back('{72'h52_00000020, 5, 32'hAAAA0001, 4, 1'b0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{72'h4E, 1, 32'h55550002, 4, 1'b0, 32'h0, 32'h0, 1'b1});
`else
        tbl.push_back('{72'h4E, 1, 32'h15, 1, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{72'h4D, 1, 32'h15, 1, 1'b0, 32'h0, 32'h0, 1'b0});
`endif
        tbl.push_back('{72'h57_12345678_00000001, 9, 32'h06, 1, 1'b1, 32'h12345678, 32'h1, 1'b1});
        tbl.push_back('{72'h52_12345678, 5, 32'h00000001, 4, 1'b0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{72'h3F, 1, 32'h42, 1, 1'b0, 32'h0, 32'h0, 1'b0});

        mem[32'h10]      = 32'h12345678;
        reset            = 1'b0;
        bus_if.rx_data   = '0;
        bus_if.rx_valid  = 1'b0;
        bus_if.tx_ready  = 1'b0;
        bus_if.bus_gnt   = 1'b1;
        repeat (3) step();

        chk("rst rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);
        chk("rst tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
        chk("rst bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        chk("rst mbus_wen", {31'd0, bus_if.mbus_wen}, 32'd0);
        chk("rst mbus_aout", bus_if.mbus_aout, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();

        for (int v = 0; v < tbl.size(); v++) begin
            w0 = wen_cnt;
            r0 = req_cnt;
            for (int j = 0; j < tbl[v].ncmd; j++)
                send_byte(tbl[v].cmd[8*(tbl[v].ncmd-1-j) +: 8]);
            for (int j = 0; j < tbl[v].nrsp; j++) begin
                recv_byte((j % 2) == 1, b);
                chk($sformatf("v%0d rsp%0d", v, j), {24'd0, b}, {24'd0, tbl[v].rsp[8*(tbl[v].nrsp-1-j) +: 8]});
            end
            step();
            chk($sformatf("v%0d busy_after", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d tx_valid_after", v), {31'd0, bus_if.tx_valid}, 32'd0);
            chk($sformatf("v%0d wen_cycles", v), wen_cnt - w0, tbl[v].wr ? 32'd1 : 32'd0);
            if (tbl[v].wr) begin
                chk($sformatf("v%0d wr_addr", v), last_aout, tbl[v].wa);
                chk($sformatf("v%0d wr_data", v), last_dout, tbl[v].wd);
            end
            if (!tbl[v].use_bus)
                chk($sformatf("v%0d no_bus_req", v), req_cnt - r0, 32'd0);
        end

        // grant withheld for 20 cycles, then backpressured response
        bus_if.bus_gnt = 1'b0;
        w0 = wen_cnt;
        send_byte(8'h57);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus_if.bus_req || bus_if.mbus_wen || bus_if.mbus_aout != 32'd0) errs++;
            step();
        end
        chk("gnt_wait bus_req/idle_bus", errs, 32'd0);
        chk("gnt_wait no_write", wen_cnt - w0, 32'd0);
        bus_if.bus_gnt = 1'b1;
        recv_byte(1'b1, b);
        chk("gnt_wait rsp", {24'd0, b}, 32'h06);
        chk("gnt_wait wen_cycles", wen_cnt - w0, 32'd1);
        chk("gnt_wait wr_addr", last_aout, 32'h40);
        chk("gnt_wait wr_data", last_dout, 32'h11223344);

        bus_if.bus_gnt = 1'b0;
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
        repeat (5) step();
        bus_if.bus_gnt = 1'b1;
        for (int j = 0; j < 4; j++) begin
            recv_byte((j % 2) == 0, b);
            chk($sformatf("gnt_rd rsp%0d", j), {24'd0, b}, {24'd0, 8'h11 * 8'(j + 1)});
        end
        step();
        chk("gnt_rd busy_after", {31'd0, busy}, 32'd0);

        // inter-byte timeout
        r0 = req_cnt;
        send_byte(8'h52);
        send_byte(8'h00);
        n = 0;
        while (!bus_if.tx_valid && n < 100) begin
            step();
            n++;
        end
        chk("timeout cycles", n, TO);
        recv_byte(1'b0, b);
        chk("timeout rsp", {24'd0, b}, 32'h15);
        step();
        chk("timeout busy_after", {31'd0, busy}, 32'd0);
        chk("timeout no_bus_req", req_cnt - r0, 32'd0);

        // reset asserted during the write cycle
        send_byte(8'h57);
        for (int j = 0; j < 8; j++) send_byte(8'h5A);
        n = 0;
        while (!bus_if.mbus_wen && n < 50) begin
            step();
            n++;
        end
        chk("rst_wr saw_wen", {31'd0, bus_if.mbus_wen}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_wr mbus_wen", {31'd0, bus_if.mbus_wen}, 32'd0);
        chk("rst_wr bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        chk("rst_wr tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
        chk("rst_wr mbus_aout", bus_if.mbus_aout, 32'd0);
        chk("rst_wr rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);
        step();
        reset = 1'b1;
        step();
        send_byte(8'h3F);
        recv_byte(1'b0, b);
        chk("rst_wr query", {24'd0, b}, 32'h42);

        step();
        chk("tx_hold_violations", hold_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
